// File: rtl/security_pkg.sv
// Shared constants and state type for the access-control slice.
package security_pkg;

    localparam int unsigned CODE_W  = 7;
    localparam int unsigned TIMER_W = 8;

    typedef enum logic [2:0] {
        LOCKED,
        CHECK,
        UNLOCKED,
        PROGRAM,
        LOCKOUT
    } lock_state_t;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock window and the timed lockout.
module lock_timer
    import security_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             expired
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    // Asserted on the last counted cycle, so the owner leaves on this decrement.
    assign expired = (value <= WIDTH'(1));

endmodule

// File: rtl/lock_controller.sv
// Code-check / timed-unlock / lockout FSM in front of the 7-bit code memory.
// SECURITY_ALARM_EN: lockout latches alarm and only reset_n releases it.
// `program` is a reserved word in SystemVerilog, so that request port is program_req.
module lock_controller
    import security_pkg::*;
#(
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned UNLOCK_CYCLES  = 8,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CODE_W-1:0] entry_code,
    input  logic              try,
    input  logic              program_req,
    input  logic [CODE_W-1:0] stored_code,
    output logic [CODE_W-1:0] store_data,
    output logic              store_en,
    output logic              unlocked,
    output logic              locked_out,
    output logic              alarm,
    output logic [3:0]        fail_count
);

    localparam logic [3:0] MAX_FAIL = 4'(MAX_TRIES);

    lock_state_t        state;
    lock_state_t        state_next;
    logic [CODE_W-1:0]  code_q;
    logic [CODE_W-1:0]  code_d;
    logic [CODE_W-1:0]  store_data_d;
    logic [3:0]         fail_d;
    logic               timer_load;
    logic               timer_dec;
    logic [TIMER_W-1:0] timer_load_value;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_expired;
`ifdef SECURITY_ALARM_EN
    logic               alarm_d;
`endif

    lock_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_load_value),
        .dec        (timer_dec),
        .value      (timer_value),
        .expired    (timer_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= LOCKED;
            code_q     <= '0;
            store_data <= '0;
            store_en   <= 1'b0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
            fail_count <= '0;
`ifdef SECURITY_ALARM_EN
            alarm      <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            code_q     <= code_d;
            store_data <= store_data_d;
            // Moore outputs registered from the state being entered.
            store_en   <= (state_next == PROGRAM);
            unlocked   <= (state_next == UNLOCKED);
            locked_out <= (state_next == LOCKOUT);
            fail_count <= fail_d;
`ifdef SECURITY_ALARM_EN
            alarm      <= alarm_d;
`endif
        end
    end

`ifndef SECURITY_ALARM_EN
    assign alarm = 1'b0;
`endif

    always_comb begin
        state_next       = state;
        code_d           = code_q;
        store_data_d     = store_data;
        fail_d           = fail_count;
        timer_load       = 1'b0;
        timer_dec        = 1'b0;
        timer_load_value = '0;
`ifdef SECURITY_ALARM_EN
        alarm_d          = alarm;
`endif
        case (state)
            LOCKED: begin
                if (try) begin
                    code_d     = entry_code;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (code_q == stored_code) begin
                    state_next       = UNLOCKED;
                    fail_d           = '0;
                    timer_load       = 1'b1;
                    timer_load_value = TIMER_W'(UNLOCK_CYCLES);
                end else begin
                    fail_d = (fail_count >= MAX_FAIL) ? MAX_FAIL : fail_count + 4'd1;
                    if (fail_d == MAX_FAIL) begin
                        state_next = LOCKOUT;
`ifdef SECURITY_ALARM_EN
                        alarm_d = 1'b1;
`else
                        timer_load       = 1'b1;
                        timer_load_value = TIMER_W'(LOCKOUT_CYCLES);
`endif
                    end else begin
                        state_next = LOCKED;
                    end
                end
            end
            UNLOCKED: begin
                timer_dec = 1'b1;
                if (program_req) begin
                    store_data_d = entry_code;
                    state_next   = PROGRAM;
                end else if (timer_expired) begin
                    state_next = LOCKED;
                end
            end
            PROGRAM: begin
                state_next = LOCKED;
            end
            LOCKOUT: begin
`ifndef SECURITY_ALARM_EN
                timer_dec = 1'b1;
                if (timer_expired) begin
                    state_next = LOCKED;
                    fail_d     = '0;
                end
`endif
            end
            default: begin
                state_next = LOCKED;
            end
        endcase
    end

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: directed scenarios plus random traffic against a cycle-count model.
module tb_lock_controller;

    localparam int MAX_T = 3;
    localparam int UNL_C = 8;
    localparam int LCK_C = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       try_s = 1'b0;
    logic       program_req = 1'b0;
    logic [6:0] entry_code = '0;
    logic [6:0] stored_code;
    logic [6:0] store_data;
    logic       store_en;
    logic       unlocked;
    logic       locked_out;
    logic       alarm;
    logic [3:0] fail_count;

    logic [6:0] mem = 7'h2A;
    assign stored_code = mem;

    lock_controller #(
        .MAX_TRIES      (MAX_T),
        .UNLOCK_CYCLES  (UNL_C),
        .LOCKOUT_CYCLES (LCK_C)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .entry_code  (entry_code),
        .try         (try_s),
        .program_req (program_req),
        .stored_code (stored_code),
        .store_data  (store_data),
        .store_en    (store_en),
        .unlocked    (unlocked),
        .locked_out  (locked_out),
        .alarm       (alarm),
        .fail_count  (fail_count)
    );

    always #5 clock = ~clock;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: remaining-cycle counters instead of explicit states.
    bit       pend_m;
    bit [6:0] code_m;
    int       unlock_left;
    int       lock_left;
    bit       forever_m;
    bit       prog_pend;
    bit [6:0] data_m;
    int       fails_m;
    bit       alarm_m;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_m = 0; code_m = '0; unlock_left = 0; lock_left = 0; forever_m = 0;
            prog_pend = 0; data_m = '0; fails_m = 0; alarm_m = 0;
            mem <= 7'h2A;
        end else if (pend_m) begin
            pend_m = 0;
            if (code_m == mem) begin
                fails_m = 0;
                unlock_left = UNL_C;
            end else begin
                if (fails_m < MAX_T) fails_m++;
                if (fails_m == MAX_T) begin
`ifdef SECURITY_ALARM_EN
                    alarm_m = 1; forever_m = 1;
`else
                    lock_left = LCK_C;
`endif
                end
            end
        end else if (prog_pend) begin
            prog_pend = 0;
            mem <= data_m;
        end else if (unlock_left > 0) begin
            if (program_req) begin
                prog_pend = 1; data_m = entry_code; unlock_left = 0;
            end else begin
                unlock_left--;
            end
        end else if (forever_m) begin
            pend_m = 0;
        end else if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails_m = 0;
        end else if (try_s) begin
            pend_m = 1; code_m = entry_code;
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            check("unlocked",   int'(unlocked),   int'(unlock_left > 0));
            check("locked_out", int'(locked_out), int'(lock_left > 0 || forever_m));
            check("store_en",   int'(store_en),   int'(prog_pend));
            check("store_data", int'(store_data), int'(data_m));
            check("fail_count", int'(fail_count), fails_m);
            check("alarm",      int'(alarm),      int'(alarm_m));
        end
    end

    task automatic step(input bit t, input logic [6:0] code, input bit p);
        try_s = t; entry_code = code; program_req = p;
        @(posedge clock);
        #2;
        try_s = 0; program_req = 0;
    endtask

    task automatic async_reset(input string name);
        reset_n = 0;
        #1;
        check({name, "_unlocked"},   int'(unlocked),   0);
        check({name, "_locked_out"}, int'(locked_out), 0);
        check({name, "_store_en"},   int'(store_en),   0);
        check({name, "_fail_count"}, int'(fail_count), 0);
        check({name, "_alarm"},      int'(alarm),      0);
        reset_n = 1;
    endtask

    task automatic fail_three();
        for (int k = 1; k <= 3; k++) begin
            step(1, 7'h15, 0);
            step(0, 7'h00, 0);
            check("lockout_fail_count", int'(fail_count), k);
        end
    endtask

    initial begin
        int n;
        int r;
        logic [6:0] c;
        reset_n = 0;
        repeat (3) @(posedge clock);
        #2;
        check("reset_unlocked", int'(unlocked), 0);
        check("reset_store_data", int'(store_data), 0);
        check("reset_fail_count", int'(fail_count), 0);
        reset_n = 1;

        // Correct code: two-edge latency, eight-cycle window.
        step(1, 7'h2A, 0);
        check("try_latency_unlocked", int'(unlocked), 0);
        step(0, 7'h00, 0);
        check("correct_unlocked", int'(unlocked), 1);
        check("correct_fail_count", int'(fail_count), 0);
        n = 0;
        while (unlocked && n < 50) begin n++; step(0, 7'h00, 0); end
        check("unlock_window", n, UNL_C);

        // Lockout after three failures; try during lockout is ignored.
        fail_three();
        check("lockout_entered", int'(locked_out), 1);
`ifdef SECURITY_ALARM_EN
        repeat (40) step(1, 7'h2A, 0);
        check("alarm_sticky", int'(alarm), 1);
        check("alarm_lockout_held", int'(locked_out), 1);
        async_reset("alarm_reset");
`else
        n = 0;
        while (locked_out && n < 100) begin n++; step(1, 7'h2A, 0); end
        check("lockout_window", n, LCK_C);
        check("lockout_cleared_fails", int'(fail_count), 0);
        check("lockout_alarm_low", int'(alarm), 0);
`endif

        // Reprogram to 7F; old code must then fail.
        step(1, 7'h2A, 0);
        step(0, 7'h00, 0);
        check("reprog_unlocked", int'(unlocked), 1);
        step(0, 7'h7F, 1);
        check("prog_store_en", int'(store_en), 1);
        check("prog_store_data", int'(store_data), 7'h7F);
        check("prog_unlocked_drop", int'(unlocked), 0);
        step(0, 7'h00, 0);
        check("prog_store_en_pulse", int'(store_en), 0);
        step(1, 7'h7F, 0);
        step(0, 7'h00, 0);
        check("new_code_unlocks", int'(unlocked), 1);
        n = 0;
        while (unlocked && n < 50) begin n++; step(0, 7'h00, 0); end
        step(1, 7'h2A, 0);
        step(0, 7'h00, 0);
        check("old_code_fails", int'(fail_count), 1);
        check("old_code_locked", int'(unlocked), 0);

        // Program on the final unlock cycle; try while unlocked is ignored.
        step(1, 7'h7F, 0);
        step(0, 7'h00, 0);
        step(1, 7'h15, 0);
        check("try_in_unlocked_fails", int'(fail_count), 0);
        check("try_in_unlocked_state", int'(unlocked), 1);
        repeat (6) step(0, 7'h00, 0);
        check("final_cycle_unlocked", int'(unlocked), 1);
        step(0, 7'h2A, 1);
        check("final_prog_store_en", int'(store_en), 1);
        check("final_prog_data", int'(store_data), 7'h2A);
        step(0, 7'h00, 0);

        // Reset mid-lockout and mid-unlock.
        fail_three();
        repeat (4) step(0, 7'h00, 0);
        async_reset("rst_lockout");
        step(1, 7'h2A, 0);
        step(0, 7'h00, 0);
        check("fresh_unlock_1", int'(unlocked), 1);
        repeat (3) step(0, 7'h00, 0);
        async_reset("rst_unlocked");
        step(1, 7'h2A, 0);
        step(0, 7'h00, 0);
        check("fresh_unlock_2", int'(unlocked), 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 2);
            c = (r == 0) ? mem : (r == 1) ? 7'h15 : 7'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 0;
                #1;
                reset_n = 1;
            end
            step(($urandom_range(0, 2) == 0), c, ($urandom_range(0, 3) == 0));
        end

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
